// File: rtl/xbar_target_arbiter.sv
// xbar_target_arbiter
// Round-robin arbiter on the target side of the simplex crossbar. NumIn
// initiator lanes compete for one target port. The winner's payload and lane
// index are forwarded, and the response path uses the index for routing.
// With AxiVldRdy=1, a grant that is stalled by the target stays locked until
// that lane completes its handshake.
// Build option: define XBAR_ARB_OUT_REG_EN to add a one-entry output register
// that carries valid, data and index. This adds one cycle of latency and keeps
// full throughput.
module xbar_target_arbiter #(
    parameter int unsigned NumIn     = 32,
    parameter int unsigned DataWidth = 32,
    parameter bit          AxiVldRdy = 1'b1,
    localparam int unsigned NumInLog = (NumIn == 1) ? 1 : $clog2(NumIn)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumIn-1:0]                valid_i,
    input  logic [NumIn-1:0][DataWidth-1:0] data_i,
    output logic [NumIn-1:0]                ready_o,
    output logic                            valid_o,
    output logic [DataWidth-1:0]            data_o,
    output logic [NumInLog-1:0]             idx_o,
    input  logic                            ready_i
);

    if (NumIn == 0) begin : g_num_in_check
        $fatal(1, "xbar_target_arbiter: NumIn must be at least 1");
    end

    localparam logic [NumInLog-1:0] LastIdx = NumInLog'(NumIn - 1);
    // A single lane never needs to be locked. With one lane, rr_q and lock_q stay 0.
    localparam bit LockEn = AxiVldRdy && (NumIn > 1);

    logic [NumInLog-1:0] rr_q, rr_d;
    logic [NumInLog-1:0] idx_q, idx_d;
    logic                lock_q, lock_d;

    logic [NumInLog-1:0] pick;
    logic [NumInLog-1:0] gnt_idx;
    logic [NumInLog-1:0] cand_idx;
    int unsigned         cand;
    logic                found;
    logic                any_valid;
    logic                accept;
    logic                hs;

    // Find the first requesting lane, scanning from rr_q and wrapping at NumIn-1.
    always_comb begin
        pick     = rr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            cand_idx = NumInLog'(cand);
            if (!found && valid_i[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    assign any_valid = |valid_i;
    assign gnt_idx   = (LockEn && lock_q) ? idx_q : pick;

    // Only the granted lane may see ready. Nothing is granted while reset is asserted.
    always_comb begin
        ready_o = '0;
        if (!rst_i) begin
            ready_o[gnt_idx] = accept;
        end
    end

    assign hs = valid_i[gnt_idx] & ready_o[gnt_idx];

    // Advance priority past the winner on a handshake. Lock a grant that is stalled.
    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        idx_d  = idx_q;
        if (hs) begin
            rr_d   = (gnt_idx == LastIdx) ? '0 : gnt_idx + NumInLog'(1);
            lock_d = 1'b0;
        end else if (LockEn && any_valid && !accept) begin
            lock_d = 1'b1;
            idx_d  = gnt_idx;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            idx_q  <= idx_d;
        end
    end

`ifdef XBAR_ARB_OUT_REG_EN
    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [NumInLog-1:0]  idx_out_q, idx_out_d;

    // The register accepts a new beat when it is empty or is draining in the same cycle.
    assign accept = ~valid_q | ready_i;

    // Load on an input handshake. Otherwise empty the register once the target takes the beat.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        idx_out_d = idx_out_q;
        if (hs) begin
            valid_d   = 1'b1;
            data_d    = data_i[gnt_idx];
            idx_out_d = gnt_idx;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output pipeline register. Reset discards any beat in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            idx_out_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            idx_out_q <= idx_out_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_out_q;
`else
    assign accept  = ready_i;
    assign valid_o = any_valid & ~rst_i;
    assign data_o  = data_i[gnt_idx];
    assign idx_o   = gnt_idx;
`endif

    // A locked request must stay asserted until it is accepted.
    a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> valid_i[idx_q]);

endmodule

// File: tb/tb_xbar_target_arbiter.sv
// Bench for xbar_target_arbiter. Four instances are tested:
//  - u4:  4 lanes, with lock
//  - u3:  3 lanes, with lock
//  - u4n: 4 lanes, no lock
//  - u1:  1 lane
// The u4 beats are tracked through a queue of expected beats.
module tb_xbar_target_arbiter;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] v4;  logic [3:0][DW-1:0] d4;  logic [3:0] r4o;  logic vo4;  logic [DW-1:0] do4;  logic [1:0] io4;  logic ri4;
    logic [2:0] v3;  logic [2:0][DW-1:0] d3;  logic [2:0] r3o;  logic vo3;  logic [DW-1:0] do3;  logic [1:0] io3;  logic ri3;
    logic [3:0] vn;  logic [3:0][DW-1:0] dn;  logic [3:0] rno;  logic von;  logic [DW-1:0] don;  logic [1:0] ion;  logic rin;
    logic [0:0] v1;  logic [0:0][DW-1:0] d1;  logic [0:0] r1o;  logic vo1;  logic [DW-1:0] do1;  logic [0:0] io1;  logic ri1;

    xbar_target_arbiter #(.NumIn(4), .DataWidth(DW), .AxiVldRdy(1'b1)) u4 (
        .clk_i(clk), .rst_i(rst), .valid_i(v4), .data_i(d4), .ready_o(r4o),
        .valid_o(vo4), .data_o(do4), .idx_o(io4), .ready_i(ri4));
    xbar_target_arbiter #(.NumIn(3), .DataWidth(DW), .AxiVldRdy(1'b1)) u3 (
        .clk_i(clk), .rst_i(rst), .valid_i(v3), .data_i(d3), .ready_o(r3o),
        .valid_o(vo3), .data_o(do3), .idx_o(io3), .ready_i(ri3));
    xbar_target_arbiter #(.NumIn(4), .DataWidth(DW), .AxiVldRdy(1'b0)) u4n (
        .clk_i(clk), .rst_i(rst), .valid_i(vn), .data_i(dn), .ready_o(rno),
        .valid_o(von), .data_o(don), .idx_o(ion), .ready_i(rin));
    xbar_target_arbiter #(.NumIn(1), .DataWidth(DW), .AxiVldRdy(1'b1)) u1 (
        .clk_i(clk), .rst_i(rst), .valid_i(v1), .data_i(d1), .ready_o(r1o),
        .valid_o(vo1), .data_o(do1), .idx_o(io1), .ready_i(ri1));

    // dut: 0=u4 1=u3 2=u4n 3=u1 4=idle
    typedef struct {
        int         dut;
        logic [3:0] valid;
        logic       rdy;
        logic       exp_v;
        logic [1:0] exp_idx;
        logic [3:0] exp_rdy;
    } vec_t;

    typedef struct {
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];

    function automatic vec_t mk(int dut, logic [3:0] va, logic rd, logic ev,
                                logic [1:0] ei, logic [3:0] er);
        vec_t v;
        v.dut = dut; v.valid = va; v.rdy = rd; v.exp_v = ev; v.exp_idx = ei; v.exp_rdy = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [1:0] idx);
        beat_t b;
        b.idx  = idx;
        b.data = 8'hA0 + {6'd0, idx};
        sb.push_back(b);
    endtask

    task automatic idle_inputs();
        v4 = '0; v3 = '0; vn = '0; v1 = '0;
        ri4 = 1'b1; ri3 = 1'b1; rin = 1'b1; ri1 = 1'b1;
    endtask

    task automatic apply(input int n, input vec_t v);
        logic          act_v;
        logic [3:0]    act_r;
        logic [1:0]    act_i;
        logic [DW-1:0] act_d;
        logic [DW-1:0] base;
        @(posedge clk);
        #1;
        idle_inputs();
        case (v.dut)
            0: begin v4 = v.valid;      ri4 = v.rdy; end
            1: begin v3 = v.valid[2:0]; ri3 = v.rdy; end
            2: begin vn = v.valid;      rin = v.rdy; end
            3: begin v1 = v.valid[0:0]; ri1 = v.rdy; end
            default: ;
        endcase
        if (v.dut == 0 && v.exp_v && v.rdy) push_beat(v.exp_idx);
        @(negedge clk);
`ifndef XBAR_ARB_OUT_REG_EN
        if (v.dut < 4) begin
            case (v.dut)
                0: begin act_v = vo4; act_r = r4o;          act_i = io4;          act_d = do4; base = 8'hA0; end
                1: begin act_v = vo3; act_r = {1'b0, r3o};  act_i = io3;          act_d = do3; base = 8'hB0; end
                2: begin act_v = von; act_r = rno;          act_i = ion;          act_d = don; base = 8'hC0; end
                default: begin act_v = vo1; act_r = {3'b0, r1o}; act_i = {1'b0, io1}; act_d = do1; base = 8'hD0; end
            endcase
            chk($sformatf("row%0d valid_o", n), act_v, v.exp_v);
            chk($sformatf("row%0d ready_o", n), act_r, v.exp_rdy);
            if (v.exp_v || v.dut == 3) chk($sformatf("row%0d idx_o", n), act_i, v.exp_idx);
            if (v.exp_v) chk($sformatf("row%0d data_o", n), act_d, base + {6'd0, v.exp_idx});
        end
`endif
    endtask

    // u4 output beats are compared in order against the expected-beat queue.
    always @(negedge clk) begin
        beat_t b;
        if (!rst && vo4 && ri4) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL u4 beat: unexpected beat idx %0d, want no beat", io4);
            end else begin
                b = sb.pop_front();
                chk("u4 beat idx", io4, b.idx);
                chk("u4 beat data", do4, b.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        d3 = {8'hB2, 8'hB1, 8'hB0};
        dn = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        d1 = 8'hD0;
        idle_inputs();

        // Test 1: 4 lanes, all valid -> strict rotation
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 4'b1111, 1'b1, 1'b1, 2'(i % 4), 4'b0001 << (i % 4)));
        // Test 2: lock a stalled grant
        tbl.push_back(mk(0, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001));
        tbl.push_back(mk(0, 4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 4'b0111, 1'b0, 1'b1, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b0111, 1'b1, 1'b1, 2'd2, 4'b0100));
        tbl.push_back(mk(0, 4'b0111, 1'b1, 1'b1, 2'd0, 4'b0001));
        // Test 3: 3 lanes, wrap at lane 2
        tbl.push_back(mk(1, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100));
        tbl.push_back(mk(1, 4'b0111, 1'b1, 1'b1, 2'd0, 4'b0001));
        tbl.push_back(mk(1, 4'b0111, 1'b1, 1'b1, 2'd1, 4'b0010));
        tbl.push_back(mk(1, 4'b0111, 1'b1, 1'b1, 2'd2, 4'b0100));
        tbl.push_back(mk(1, 4'b0111, 1'b1, 1'b1, 2'd0, 4'b0001));
        // Test 4: no-lock instance follows the requests while stalled
        tbl.push_back(mk(2, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000));
        tbl.push_back(mk(2, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000));
        tbl.push_back(mk(2, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000));
        tbl.push_back(mk(2, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000));
        // Test 6: single lane
        tbl.push_back(mk(3, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001));
        tbl.push_back(mk(3, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0000));
        tbl.push_back(mk(3, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001));
        tbl.push_back(mk(3, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(4, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000));

        // Reset state: requests are present, but nothing is offered or granted
        v4 = 4'b1111; vn = 4'b1111; v1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset u4 valid_o", vo4, 1'b0);
        chk("reset u4 ready_o", r4o, 4'b0000);
        chk("reset u4n ready_o", rno, 4'b0000);
        chk("reset u1 valid_o", vo1, 1'b0);
        chk("reset u1 ready_o", r1o, 1'b0);
        idle_inputs();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);
        chk("u4 queue drained", sb.size(), 0);

        // Asynchronous reset in the middle of a cycle clears the no-lock instance
        @(posedge clk); #1;
        idle_inputs(); vn = 4'b0010; rin = 1'b1;
        @(negedge clk);
`ifndef XBAR_ARB_OUT_REG_EN
        chk("u4n grant lane1", rno, 4'b0010);
`endif
        @(posedge clk); #1;
        vn = 4'b1111; rin = 1'b0;
        @(negedge clk);
`ifndef XBAR_ARB_OUT_REG_EN
        chk("u4n pick after hs", ion, 2'd2);
`endif
        chk("u4n valid before rst", von, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("u4n valid_o async rst", von, 1'b0);
        chk("u4n ready_o async rst", rno, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
`ifndef XBAR_ARB_OUT_REG_EN
        #1;
        chk("u4n pick after rst", ion, 2'd0);
`else
        @(negedge clk);
        chk("u4n valid after rst", von, 1'b1);
        chk("u4n idx after rst", ion, 2'd0);
`endif
        @(posedge clk); #1;
        idle_inputs();

`ifdef XBAR_ARB_OUT_REG_EN
        // Test 5: output register latency, stall and resume
        @(posedge clk); #1;
        v4 = 4'b1111; ri4 = 1'b1; push_beat(2'd0);
        @(negedge clk);
        chk("reg first cycle valid_o", vo4, 1'b0);
        @(posedge clk); #1;
        push_beat(2'd1);
        @(negedge clk);
        chk("reg second cycle valid_o", vo4, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            ri4 = 1'b0;
            @(negedge clk);
            chk("reg stall ready_o", r4o, 4'b0000);
            chk("reg stall idx_o", io4, 2'd1);
            chk("reg stall data_o", do4, 8'hA1);
        end
        @(posedge clk); #1;
        ri4 = 1'b1; push_beat(2'd2);
        @(negedge clk);
        chk("reg resume locked grant", r4o, 4'b0100);
        @(posedge clk); #1;
        v4 = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reg queue drained", sb.size(), 0);

        // Test 6 with the output register: single lane
        @(posedge clk); #1;
        v1 = 1'b1; ri1 = 1'b1;
        @(negedge clk);
        chk("reg u1 idx_o", io1, 1'b0);
        @(posedge clk); #1;
        v1 = 1'b0; ri1 = 1'b0;
        @(negedge clk);
        chk("reg u1 valid_o", vo1, 1'b1);
        chk("reg u1 data_o", do1, 8'hD0);
        chk("reg u1 ready_o full", r1o, 1'b0);
        @(posedge clk); #1;
        ri1 = 1'b1;
        @(negedge clk);
        chk("reg u1 ready_o drain", r1o, 1'b1);
        chk("reg u1 held valid_o", vo1, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reg u1 drained valid_o", vo1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
